// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in/serial-out transmitter, one bit every DIV clocks
module piso_shift_tx #(
  parameter int WIDTH     = 4,
  parameter int DIV       = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] Pin,
  output logic             Dout,
  output logic             busy,
  output logic             done
);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [DW-1:0]    div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             div_wrap;
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    div_d    = div_q;
    bit_d    = bit_q;
    div_wrap = div_q == DIV_LAST;
    case (state_q)
      IDLE: if (start) begin
        state_d = SHIFT;
        sh_d    = Pin;
        div_d   = '0;
        bit_d   = '0;
      end
      SHIFT: begin
        div_d = div_wrap ? '0 : div_q + 1'b1;
        if (div_wrap) begin
          sh_d    = MSB_FIRST ? sh_q << 1 : sh_q >> 1;
          bit_d   = bit_q + 1'b1;
          state_d = (bit_q == BIT_LAST) ? DONE : SHIFT;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // Outputs are registered from next-state so they line up with the state they describe
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      sh_q    <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      Dout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      Dout    <= (state_d == SHIFT) && (MSB_FIRST ? sh_d[WIDTH-1] : sh_d[0]);
      busy    <= state_d == SHIFT;
      done    <= state_d == DONE;
    end
  end
endmodule

// File: tb/tb_piso_shift_tx.sv
// tb_piso_shift_tx: scoreboard bench for MSB-first, LSB-first and DIV=1 transmitters
module tb_piso_shift_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       clr, start, start1;
  logic [3:0] pin, pin1;
  logic       dm, bm, km, dl, bl, kl, d1, b1, k1;
  logic [3:0] rx;
  logic [2:0] qm[$], ql[$], q1[$];
  int checks = 0;
  int errors = 0;
  piso_shift_tx #(.WIDTH(4), .DIV(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .clr(clr), .start(start), .Pin(pin), .Dout(dm), .busy(bm), .done(km));
  piso_shift_tx #(.WIDTH(4), .DIV(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .clr(clr), .start(start), .Pin(pin), .Dout(dl), .busy(bl), .done(kl));
  piso_shift_tx #(.WIDTH(4), .DIV(1), .MSB_FIRST(1'b1)) u_d1 (
    .clk(clk), .clr(clr), .start(start1), .Pin(pin1), .Dout(d1), .busy(b1), .done(k1));
  // SIPO receiver model: takes one bit per clock while the DIV=1 transmitter is busy
  always @(posedge clk or negedge clr)
    if (!clr) rx <= 4'h0;
    else if (b1) rx <= {rx[2:0], d1};
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic push(input int which, input logic [2:0] e);
    if (which == 0) qm.push_back(e);
    else if (which == 1) ql.push_back(e);
    else q1.push_back(e);
  endtask
  task automatic push_word(input int which, input logic [3:0] w, input int div, input bit msb);
    for (int c = 1; c <= 4 * div; c++) begin
      int k = (c - 1) / div;
      push(which, {msb ? w[3-k] : w[k], 1'b1, 1'b0});
    end
    push(which, 3'b001);
  endtask
  task automatic tick();
    @(negedge clk);
    if (qm.size() > 0) chk("msb{dout,busy,done}", {1'b0, dm, bm, km}, {1'b0, qm.pop_front()});
    if (ql.size() > 0) chk("lsb{dout,busy,done}", {1'b0, dl, bl, kl}, {1'b0, ql.pop_front()});
    if (q1.size() > 0) chk("div1{dout,busy,done}", {1'b0, d1, b1, k1}, {1'b0, q1.pop_front()});
  endtask
  initial begin
    clr = 1'b0; start = 1'b1; pin = 4'b1011; start1 = 1'b1; pin1 = 4'hA;
    // T1: reset held with start high
    for (int i = 0; i < 4; i++) begin push(0, 3'b000); push(1, 3'b000); push(2, 3'b000); end
    repeat (4) tick();
    // T2/T3/T4: release with start still high; first edge accepts
    start1 = 1'b0; clr = 1'b1;
    push_word(0, 4'b1011, 4, 1'b1);
    push_word(1, 4'b1011, 4, 1'b0);
    for (int i = 0; i < 2; i++) begin push(0, 3'b000); push(1, 3'b000); end
    for (int c = 1; c <= 19; c++) begin
      tick();
      start = (c == 5 || c == 17);
      pin = 4'b0000;
    end
    // T5: abort mid-bit then fresh word
    start = 1'b1; pin = 4'b1011;
    push_word(0, 4'b1011, 4, 1'b1);
    push_word(1, 4'b1011, 4, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      tick();
      start = 1'b0;
    end
    #2 clr = 1'b0;
    #1;
    chk("abort_msb", {1'b0, dm, bm, km}, 4'b0000);
    chk("abort_lsb", {1'b0, dl, bl, kl}, 4'b0000);
    qm.delete(); ql.delete();
    for (int i = 0; i < 2; i++) begin push(0, 3'b000); push(1, 3'b000); end
    repeat (2) tick();
    clr = 1'b1; pin = 4'b0110; start = 1'b1;
    push_word(0, 4'b0110, 4, 1'b1);
    push_word(1, 4'b0110, 4, 1'b0);
    push(0, 3'b000); push(1, 3'b000);
    for (int c = 1; c <= 18; c++) begin
      tick();
      start = 1'b0;
    end
    // T6: DIV=1 back-to-back with start held high, looped into the receiver
    start1 = 1'b1; pin1 = 4'hA;
    push_word(2, 4'hA, 1, 1'b1);
    push(2, 3'b000);
    push_word(2, 4'h5, 1, 1'b1);
    push(2, 3'b000); push(2, 3'b000);
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 1) pin1 = 4'h5;
      if (c == 5) chk("rx_word0", rx, 4'hA);
      if (c == 11) begin
        chk("rx_word1", rx, 4'h5);
        start1 = 1'b0;
      end
    end
    chk("scoreboard_drained", 4'(qm.size() + ql.size() + q1.size()), 4'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
